// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA timing generator.
package vga_pkg;

  typedef enum logic [1:0] {SYNC, BACK, ACTIVE, FRONT} vga_phase_t;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;

  function automatic vga_phase_t next_phase(input vga_phase_t ph);
    case (ph)
      SYNC:    return BACK;
      BACK:    return ACTIVE;
      ACTIVE:  return FRONT;
      default: return SYNC;
    endcase
  endfunction

endpackage

// File: rtl/vga_axis_fsm.sv
// One timing axis: SYNC -> BACK -> ACTIVE -> FRONT phase walker with
// registered sync/valid/address outputs computed from the next state.
//
// state  | meaning
// SYNC   | sync pulse asserted (level = POL)
// BACK   | back porch, blanked
// ACTIVE | visible region, addr counts 0..ACTIVE-1
// FRONT  | front porch, blanked; last count is the wrap point
module vga_axis_fsm #(
  parameter int ACTIVE = 640,
  parameter int FRONT  = 16,
  parameter int SYNC   = 96,
  parameter int BACK   = 48,
  parameter bit POL    = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        advance,
  output logic                        sync,
  output logic                        addr_valid,
  output logic [$clog2(ACTIVE)-1:0]   addr,
  output vga_pkg::vga_phase_t         phase,
  output logic                        at_wrap
);

  localparam int MAX_AB  = (ACTIVE > BACK) ? ACTIVE : BACK;
  localparam int MAX_FS  = (FRONT > SYNC) ? FRONT : SYNC;
  localparam int MAX_LEN = (MAX_AB > MAX_FS) ? MAX_AB : MAX_FS;
  localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int AW      = $clog2(ACTIVE);

  localparam logic [CW-1:0] SYNC_LAST   = CW'(SYNC - 1);
  localparam logic [CW-1:0] BACK_LAST   = CW'(BACK - 1);
  localparam logic [CW-1:0] ACTIVE_LAST = CW'(ACTIVE - 1);
  localparam logic [CW-1:0] FRONT_LAST  = CW'(FRONT - 1);

  if (ACTIVE < 1 || FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_bad_phase_len
    $error("vga_axis_fsm: every phase length must be at least 1");
  end

  vga_pkg::vga_phase_t phase_q, phase_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       phase_last;
  logic                sync_q, sync_d;
  logic                addr_valid_q, addr_valid_d;
  logic [AW-1:0]       addr_q, addr_d;

  always_comb begin
    case (phase_q)
      vga_pkg::SYNC:   phase_last = SYNC_LAST;
      vga_pkg::BACK:   phase_last = BACK_LAST;
      vga_pkg::ACTIVE: phase_last = ACTIVE_LAST;
      default:         phase_last = FRONT_LAST;
    endcase

    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (advance) begin
      if (cnt_q == phase_last) begin
        phase_d = vga_pkg::next_phase(phase_q);
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Outputs come from the next state so they line up with the phase flops.
    sync_d       = (phase_d == vga_pkg::SYNC) ? POL : ~POL;
    addr_valid_d = (phase_d == vga_pkg::ACTIVE);
    addr_d       = addr_valid_d ? cnt_d[AW-1:0] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q      <= vga_pkg::FRONT;
      cnt_q        <= FRONT_LAST;
      sync_q       <= ~POL;
      addr_valid_q <= 1'b0;
      addr_q       <= '0;
    end else begin
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      sync_q       <= sync_d;
      addr_valid_q <= addr_valid_d;
      addr_q       <= addr_d;
    end
  end

  assign sync       = sync_q;
  assign addr_valid = addr_valid_q;
  assign addr       = addr_q;
  assign phase      = phase_q;
  assign at_wrap    = (phase_q == vga_pkg::FRONT) && (cnt_q == FRONT_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: horizontal axis steps per enabled pixel clock,
// vertical axis steps on each horizontal wrap.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FRONT  = VGA_H_FRONT,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BACK   = VGA_H_BACK,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FRONT  = VGA_V_FRONT,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BACK   = VGA_V_BACK,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  output logic                          vga_hs,
  output logic                          vga_vs,
  output logic                          addr_x_valid,
  output logic [$clog2(H_ACTIVE)-1:0]   addr_x,
  output logic                          addr_y_valid,
  output logic [$clog2(V_ACTIVE)-1:0]   addr_y,
  output logic                          pixel_valid,
  output logic                          line_start,
  output logic                          frame_start
);

  vga_phase_t h_phase, v_phase;
  logic       h_at_wrap, v_at_wrap;
  logic       v_advance;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       unused_phases;

  assign v_advance = enable & h_at_wrap;

  vga_axis_fsm #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .POL(HS_POL)
  ) u_h_axis (
    .clk        (clk),
    .reset      (reset),
    .advance    (enable),
    .sync       (vga_hs),
    .addr_valid (addr_x_valid),
    .addr       (addr_x),
    .phase      (h_phase),
    .at_wrap    (h_at_wrap)
  );

  vga_axis_fsm #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .POL(VS_POL)
  ) u_v_axis (
    .clk        (clk),
    .reset      (reset),
    .advance    (v_advance),
    .sync       (vga_vs),
    .addr_valid (addr_y_valid),
    .addr       (addr_y),
    .phase      (v_phase),
    .at_wrap    (v_at_wrap)
  );

  // A wrap always lands in SYNC count 0, so the wrap flags mark line/frame starts.
  always_comb begin
    line_start_d  = enable ? h_at_wrap : line_start_q;
    frame_start_d = enable ? (h_at_wrap & v_at_wrap) : frame_start_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign line_start    = line_start_q;
  assign frame_start   = frame_start_q;
  assign pixel_valid   = addr_x_valid & addr_y_valid;
  assign unused_phases = ^{h_phase, v_phase};

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen across default, tall, inverted-polarity
// and tiny timing configurations.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;
  logic en;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // defaults
  logic       d_hs, d_vs, d_xv, d_yv, d_pv, d_ls, d_fs;
  logic [9:0] d_x;
  logic [8:0] d_y;
  // narrow lines, default vertical
  logic       v_hs, v_vs, v_xv, v_yv, v_pv, v_ls, v_fs;
  logic [2:0] v_x;
  logic [8:0] v_y;
  // inverted polarity, short frame
  logic       p_hs, p_vs, p_xv, p_yv, p_pv, p_ls, p_fs;
  logic [9:0] p_x;
  logic [1:0] p_y;
  // tiny
  logic       s_hs, s_vs, s_xv, s_yv, s_pv, s_ls, s_fs;
  logic [1:0] s_x;
  logic [0:0] s_y;

  vga_timing_gen u_def (
    .clk(clk), .reset(rst), .enable(en),
    .vga_hs(d_hs), .vga_vs(d_vs), .addr_x_valid(d_xv), .addr_x(d_x),
    .addr_y_valid(d_yv), .addr_y(d_y), .pixel_valid(d_pv),
    .line_start(d_ls), .frame_start(d_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(1), .H_BACK(1)
  ) u_vert (
    .clk(clk), .reset(rst), .enable(en),
    .vga_hs(v_hs), .vga_vs(v_vs), .addr_x_valid(v_xv), .addr_x(v_x),
    .addr_y_valid(v_yv), .addr_y(v_y), .pixel_valid(v_pv),
    .line_start(v_ls), .frame_start(v_fs)
  );

  vga_timing_gen #(
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_pol (
    .clk(clk), .reset(rst), .enable(en),
    .vga_hs(p_hs), .vga_vs(p_vs), .addr_x_valid(p_xv), .addr_x(p_x),
    .addr_y_valid(p_yv), .addr_y(p_y), .pixel_valid(p_pv),
    .line_start(p_ls), .frame_start(p_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) u_small (
    .clk(clk), .reset(rst), .enable(en),
    .vga_hs(s_hs), .vga_vs(s_vs), .addr_x_valid(s_xv), .addr_x(s_x),
    .addr_y_valid(s_yv), .addr_y(s_y), .pixel_valid(s_pv),
    .line_start(s_ls), .frame_start(s_fs)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [25:0] act, exp;
    logic [3:0]  act4, exp4;
    rst = 1'b1;
    en  = 1'b1;
    #2;
    act = {d_hs, d_vs, d_xv, d_x, d_yv, d_y, d_pv, d_ls, d_fs};
    exp = {1'b1, 1'b1, 1'b0, 10'd0, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL reset_async_def got=%h exp=%h", act, exp);
    end
    tick();
    tick();
    act = {d_hs, d_vs, d_xv, d_x, d_yv, d_y, d_pv, d_ls, d_fs};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL reset_held_def got=%h exp=%h", act, exp);
    end
    act4 = {p_hs, p_vs, p_ls, p_fs};
    checks++;
    if (act4 !== 4'b0000) begin
      failures++;
      $display("FAIL reset_held_pol got=%b exp=0000", act4);
    end
    rst = 1'b0;
    tick();
    act4 = {d_hs, d_vs, d_ls, d_fs};
    exp4 = 4'b0011;
    checks++;
    if (act4 !== exp4) begin
      failures++;
      $display("FAIL first_edge_def hs,vs,ls,fs got=%b exp=%b", act4, exp4);
    end
    act4 = {p_hs, p_vs, p_ls, p_fs};
    checks++;
    if (act4 !== 4'b1111) begin
      failures++;
      $display("FAIL first_edge_pol hs,vs,ls,fs got=%b exp=1111", act4);
    end
    act4 = {s_hs, s_vs, s_ls, s_fs};
    checks++;
    if (act4 !== 4'b0011) begin
      failures++;
      $display("FAIL first_edge_small hs,vs,ls,fs got=%b exp=0011", act4);
    end
  endtask

  task automatic test_line_timing();
    logic [25:0] act, exp;
    do_reset();
    for (int ln = 0; ln < 3; ln++) begin
      for (int c = 0; c < 800; c++) begin
        logic       e_xv;
        logic [9:0] e_x;
        tick();
        e_xv = (c >= 144) && (c < 784);
        e_x  = e_xv ? 10'(c - 144) : 10'd0;
        exp  = {(c >= 96), (ln >= 2), e_xv, e_x, 1'b0, 9'd0, 1'b0, (c == 0), (ln == 0 && c == 0)};
        act  = {d_hs, d_vs, d_xv, d_x, d_yv, d_y, d_pv, d_ls, d_fs};
        checks++;
        if (act !== exp) begin
          failures++;
          $display("FAIL line_timing ln=%0d c=%0d got=%h exp=%h", ln, c, act, exp);
        end
      end
    end
  endtask

  task automatic test_enable_hold();
    logic [2:0] act3;
    do_reset();
    tick();
    act3 = {d_ls, d_fs, d_hs};
    checks++;
    if (act3 !== 3'b110) begin
      failures++;
      $display("FAIL hold_start ls,fs,hs got=%b exp=110", act3);
    end
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      act3 = {d_ls, d_fs, d_hs};
      checks++;
      if (act3 !== 3'b110) begin
        failures++;
        $display("FAIL hold_disabled%0d ls,fs,hs got=%b exp=110", i, act3);
      end
    end
    en = 1'b1;
    tick();
    act3 = {d_ls, d_fs, d_hs};
    checks++;
    if (act3 !== 3'b000) begin
      failures++;
      $display("FAIL hold_resume ls,fs,hs got=%b exp=000", act3);
    end
  endtask

  task automatic test_enable_active();
    logic       en_seq [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [9:0] x_seq  [5] = '{10'd11, 10'd11, 10'd11, 10'd12, 10'd13};
    do_reset();
    repeat (155) tick();
    checks++;
    if ({d_xv, d_x} !== {1'b1, 10'd10}) begin
      failures++;
      $display("FAIL enable_pre xv,x got=%b,%0d exp=1,10", d_xv, d_x);
    end
    for (int i = 0; i < 5; i++) begin
      en = en_seq[i];
      tick();
      checks++;
      if ({d_xv, d_x} !== {1'b1, x_seq[i]}) begin
        failures++;
        $display("FAIL enable_step%0d xv,x got=%b,%0d exp=1,%0d", i, d_xv, d_x, x_seq[i]);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_vertical();
    logic [14:0] act, exp;
    int first_yv  = -1;
    int y479_line = -1;
    int fs_prev   = -1;
    int period    = -1;
    do_reset();
    for (int k = 0; k < 2 * 5775; k++) begin
      int         ln, c;
      logic       e_yv;
      logic [8:0] e_y;
      tick();
      ln   = (k / 11) % 525;
      c    = k % 11;
      e_yv = (ln >= 35) && (ln < 515);
      e_y  = e_yv ? 9'(ln - 35) : 9'd0;
      exp  = {(ln >= 2), e_yv, e_y, (e_yv && c >= 2 && c < 10), (c == 0), (ln == 0 && c == 0), (c != 0)};
      act  = {v_vs, v_yv, v_y, v_pv, v_ls, v_fs, v_hs};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL vertical k=%0d ln=%0d c=%0d got=%h exp=%h", k, ln, c, act, exp);
      end
      if (v_yv === 1'b1 && first_yv < 0) first_yv = k / 11;
      if (v_yv === 1'b1 && v_y === 9'd479 && y479_line < 0) y479_line = k / 11;
      if (v_fs === 1'b1) begin
        if (fs_prev >= 0 && period < 0) period = k - fs_prev;
        fs_prev = k;
      end
    end
    checks++;
    if (first_yv != 35) begin
      failures++;
      $display("FAIL yvalid_first_line got=%0d exp=35", first_yv);
    end
    checks++;
    if (y479_line != 514) begin
      failures++;
      $display("FAIL y479_line got=%0d exp=514", y479_line);
    end
    checks++;
    if (period != 5775) begin
      failures++;
      $display("FAIL frame_period_tall got=%0d exp=5775", period);
    end
  endtask

  task automatic test_polarity();
    logic [1:0] act, exp;
    do_reset();
    for (int k = 0; k < 8 * 800; k++) begin
      int ln, c;
      tick();
      ln  = k / 800;
      c   = k % 800;
      exp = {(c < 96), (ln < 2)};
      act = {p_hs, p_vs};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL polarity ln=%0d c=%0d hs,vs got=%b exp=%b", ln, c, act, exp);
      end
    end
  endtask

  task automatic test_small();
    logic [10:0] act, exp;
    int fs_prev = -1;
    int period  = -1;
    do_reset();
    for (int k = 0; k < 70; k++) begin
      int         ln, c;
      logic       e_xv, e_yv;
      logic [1:0] e_x;
      logic [0:0] e_y;
      tick();
      ln   = (k / 7) % 5;
      c    = k % 7;
      e_xv = (c >= 2) && (c < 6);
      e_x  = e_xv ? 2'(c - 2) : 2'd0;
      e_yv = (ln == 2) || (ln == 3);
      e_y  = e_yv ? 1'(ln - 2) : 1'b0;
      exp  = {(c != 0), e_xv, e_x, (ln != 0), e_yv, e_y, (e_xv && e_yv), (c == 0), (ln == 0 && c == 0)};
      act  = {s_hs, s_xv, s_x, s_vs, s_yv, s_y, s_pv, s_ls, s_fs};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL small k=%0d ln=%0d c=%0d got=%b exp=%b", k, ln, c, act, exp);
      end
      if (s_fs === 1'b1) begin
        if (fs_prev >= 0 && period < 0) period = k - fs_prev;
        fs_prev = k;
      end
    end
    checks++;
    if (period != 35) begin
      failures++;
      $display("FAIL frame_period_small got=%0d exp=35", period);
    end
  endtask

  task automatic test_mid_reset();
    logic [25:0] act, exp;
    logic [17:0] vact, vexp;
    logic [4:0]  act5;
    do_reset();
    repeat (445) tick();
    checks++;
    if ({d_xv, d_x} !== {1'b1, 10'd300}) begin
      failures++;
      $display("FAIL midrst_pre_def xv,x got=%b,%0d exp=1,300", d_xv, d_x);
    end
    #2;
    rst = 1'b1;
    #1;
    act = {d_hs, d_vs, d_xv, d_x, d_yv, d_y, d_pv, d_ls, d_fs};
    exp = {1'b1, 1'b1, 1'b0, 10'd0, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL midrst_async_def got=%h exp=%h", act, exp);
    end
    rst = 1'b0;
    tick();
    act5 = {d_ls, d_fs, d_hs, d_vs, d_xv};
    checks++;
    if (act5 !== 5'b11000) begin
      failures++;
      $display("FAIL midrst_release_def ls,fs,hs,vs,xv got=%b exp=11000", act5);
    end

    do_reset();
    repeat (1493) tick();
    checks++;
    if ({v_yv, v_y, v_xv, v_x} !== {1'b1, 9'd100, 1'b1, 3'd5}) begin
      failures++;
      $display("FAIL midrst_pre_tall yv,y,xv,x got=%b,%0d,%b,%0d exp=1,100,1,5", v_yv, v_y, v_xv, v_x);
    end
    #2;
    rst = 1'b1;
    #1;
    vact = {v_hs, v_vs, v_xv, v_x, v_yv, v_y, v_pv, v_ls, v_fs};
    vexp = {1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (vact !== vexp) begin
      failures++;
      $display("FAIL midrst_async_tall got=%h exp=%h", vact, vexp);
    end
    rst = 1'b0;
    tick();
    act5 = {v_ls, v_fs, v_hs, v_vs, v_yv};
    checks++;
    if (act5 !== 5'b11000) begin
      failures++;
      $display("FAIL midrst_release_tall ls,fs,hs,vs,yv got=%b exp=11000", act5);
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    test_reset();
    test_line_timing();
    test_enable_hold();
    test_enable_active();
    test_vertical();
    test_polarity();
    test_small();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
